// File: rtl/fdn_coef_pkg.sv
// Shared types and sizing helpers for the FDN coefficient loader.
package fdn_coef_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_PEND = 2'd1,
        ST_DROP = 2'd2
    } coef_state_e;

    function automatic int unsigned coef_total(input int unsigned n_ch, input int unsigned n_dn);
        return n_ch * n_dn;
    endfunction

    // A single-entry set still needs a one-bit address.
    function automatic int unsigned coef_addr_w(input int unsigned total);
        return (total > 32'd1) ? $clog2(total) : 32'd1;
    endfunction

endpackage

// File: rtl/fdn_coef_bank.sv
// Two-bank coefficient storage: one write port, one registered read port.
module fdn_coef_bank #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 3
)(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic          wr_bank_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic          rd_bank_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [0:(2**(AW+1))-1];
    logic [DW-1:0] rd_data_q;

    // Storage write; bank select is the address MSB.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
        end
    end

    // Registered read; the output holds when no read is requested.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= {DW{1'b0}};
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[{rd_bank_i, rd_addr_i}];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fdn_coef_loader.sv
// AXI-Stream coefficient loader: fills the shadow bank with a length-checked set
// and swaps it in at the next frame boundary.
module fdn_coef_loader
    import fdn_coef_pkg::*;
#(
    parameter  int unsigned wight_coef_i = 16,
    parameter  int unsigned N_chanals    = 16,
    parameter  int unsigned N_DN         = 4,
    localparam int unsigned TOTAL        = coef_total(N_chanals, N_DN),
    localparam int unsigned AW           = coef_addr_w(TOTAL)
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vld_coef_in,
    input  logic                    last_coef_in,
    output logic                    readi_coef_in,
    input  logic [wight_coef_i-1:0] coefReIn,
    input  logic [wight_coef_i-1:0] coefImIn,
    input  logic                    frame_start,
    input  logic                    rd_en,
    input  logic [AW-1:0]           rd_addr,
    output logic [wight_coef_i-1:0] rd_coefRe,
    output logic [wight_coef_i-1:0] rd_coefIm,
    output logic                    coef_valid,
    output logic                    err_short,
    output logic                    err_long
);

    localparam int unsigned         DW       = 2 * wight_coef_i;
    localparam logic [AW-1:0]       LAST_IDX = AW'(TOTAL - 1);

    coef_state_e   state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          bank_q, bank_d;
    logic          valid_q, valid_d;
    logic          ready_q, ready_d;
    logic          err_short_q, err_short_d;
    logic          err_long_q, err_long_d;
    logic          beat_s;
    logic          wr_en_s;
    logic [DW-1:0] rd_data_s;

    assign beat_s = vld_coef_in && ready_q;

    // Next-state logic for the load FSM, beat counter, bank pointer and error pulses.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bank_d      = bank_q;
        valid_d     = valid_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        wr_en_s     = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (beat_s) begin
                    wr_en_s = 1'b1;
                    if (last_coef_in) begin
                        cnt_d = {AW{1'b0}};
                        if (cnt_q == LAST_IDX) begin
                            state_d = ST_PEND;
                        end else begin
                            err_short_d = 1'b1;
                        end
                    end else if (cnt_q == LAST_IDX) begin
                        err_long_d = 1'b1;
                        cnt_d      = {AW{1'b0}};
                        state_d    = ST_DROP;
                    end else begin
                        cnt_d = cnt_q + AW'(1'b1);
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_PEND: begin
                if (frame_start) begin
                    bank_d  = ~bank_q;
                    valid_d = 1'b1;
                    cnt_d   = {AW{1'b0}};
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_PEND;
                end
            end
            ST_DROP: begin
                if (beat_s && last_coef_in) begin
                    cnt_d   = {AW{1'b0}};
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                cnt_d   = {AW{1'b0}};
                state_d = ST_LOAD;
            end
        endcase
        // tready is registered, so it follows the state being entered.
        ready_d = (state_d != ST_PEND);
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_LOAD;
            cnt_q       <= {AW{1'b0}};
            bank_q      <= 1'b0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bank_q      <= bank_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    // Writes go to the shadow bank; reads use the bank pointer before any swap this cycle.
    fdn_coef_bank #(
        .DW (DW),
        .AW (AW)
    ) u_bank (
        .clk_i     (clk),
        .rst_ni    (rst),
        .wr_en_i   (wr_en_s),
        .wr_bank_i (~bank_q),
        .wr_addr_i (cnt_q),
        .wr_data_i ({coefReIn, coefImIn}),
        .rd_en_i   (rd_en),
        .rd_bank_i (bank_q),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data_s)
    );

    assign readi_coef_in = ready_q;
    assign coef_valid    = valid_q;
    assign err_short     = err_short_q;
    assign err_long      = err_long_q;
    assign rd_coefRe     = rd_data_s[DW-1:wight_coef_i];
    assign rd_coefIm     = rd_data_s[wight_coef_i-1:0];

endmodule

// File: tb/tb_fdn_coef_loader.sv
// Scoreboard bench for fdn_coef_loader (4 channels x 2 beams).
module tb_fdn_coef_loader;

    localparam int W   = 16;
    localparam int NCH = 4;
    localparam int NDN = 2;
    localparam int TOT = NCH * NDN;

    logic          clk         = 1'b0;
    logic          rst         = 1'b0;
    logic          vld         = 1'b0;
    logic          last        = 1'b0;
    logic          fs          = 1'b0;
    logic          rd_en       = 1'b0;
    logic [2:0]    rd_addr     = 3'd0;
    logic [W-1:0]  re_in       = 16'd0;
    logic [W-1:0]  im_in       = 16'd0;
    logic          readi;
    logic          coef_valid;
    logic          err_short;
    logic          err_long;
    logic [W-1:0]  rd_re;
    logic [W-1:0]  rd_im;

    int            n_checks    = 0;
    int            n_errors    = 0;
    logic [W-1:0]  exp_re_q[$];
    logic [W-1:0]  exp_im_q[$];
    int            exp_err_q[$];
    int            act_base    = 0;
    logic          model_valid = 1'b0;
    logic          rd_pend     = 1'b0;
    logic [W-1:0]  mon_re;
    logic [W-1:0]  mon_im;
    int            mon_err;

    always #5 clk = ~clk;

    fdn_coef_loader #(
        .wight_coef_i (W),
        .N_chanals    (NCH),
        .N_DN         (NDN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .vld_coef_in   (vld),
        .last_coef_in  (last),
        .readi_coef_in (readi),
        .coefReIn      (re_in),
        .coefImIn      (im_in),
        .frame_start   (fs),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_coefRe     (rd_re),
        .rd_coefIm     (rd_im),
        .coef_valid    (coef_valid),
        .err_short     (err_short),
        .err_long      (err_long)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a read issued at one edge is compared at the following falling edge.
    always @(posedge clk) rd_pend <= rd_en;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_re_q.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                mon_re = exp_re_q.pop_front();
                mon_im = exp_im_q.pop_front();
                check("rd_re", {16'd0, rd_re}, {16'd0, mon_re});
                check("rd_im", {16'd0, rd_im}, {16'd0, mon_im});
            end
        end
        if (err_short || err_long) begin
            if (exp_err_q.size() == 0) begin
                check("err_unexpected", {30'd0, err_short, err_long}, 32'd0);
            end else begin
                mon_err = exp_err_q.pop_front();
                check("err_kind", {30'd0, err_short, err_long}, mon_err);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int v, input logic l, input logic f, input bit gaps);
        int t;
        if (gaps && ($urandom_range(1, 0) == 1)) cyc();
        vld   = 1'b1;
        last  = l;
        fs    = f;
        re_in = 16'(v);
        im_in = 16'(-v);
        t = 0;
        while (!readi && t < 50) begin
            cyc();
            t++;
        end
        if (t >= 50) check("beat_timeout", 32'd1, 32'd0);
        cyc();
        vld  = 1'b0;
        last = 1'b0;
        fs   = 1'b0;
    endtask

    task automatic send_set(input int base, input bit gaps);
        for (int n = 0; n < TOT; n++) send_beat(base + n, (n == TOT - 1), 1'b0, gaps);
        check("pend_readi_low", {31'd0, readi}, 32'd0);
        check("pend_valid", {31'd0, coef_valid}, {31'd0, model_valid});
    endtask

    task automatic swap(input int new_base);
        fs = 1'b1;
        cyc();
        fs = 1'b0;
        act_base    = new_base;
        model_valid = 1'b1;
        check("swap_valid", {31'd0, coef_valid}, 32'd1);
        check("swap_readi", {31'd0, readi}, 32'd1);
    endtask

    task automatic push_read(input int k);
        rd_en   = 1'b1;
        rd_addr = 3'(k);
        exp_re_q.push_back(16'(act_base + k));
        exp_im_q.push_back(16'(-(act_base + k)));
    endtask

    task automatic read_all();
        for (int k = 0; k < TOT; k++) begin
            push_read(k);
            cyc();
        end
        rd_en = 1'b0;
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        repeat (3) cyc();
        check("rst_readi", {31'd0, readi}, 32'd0);
        check("rst_valid", {31'd0, coef_valid}, 32'd0);
        check("rst_rd_re", {16'd0, rd_re}, 32'd0);
        check("rst_rd_im", {16'd0, rd_im}, 32'd0);
        check("rst_errs", {30'd0, err_short, err_long}, 32'd0);
        rst = 1'b1;
        cyc();
        check("readi_after_rst", {31'd0, readi}, 32'd1);

        // Basic set; frame_start together with the final beat must be ignored
        for (int n = 0; n < TOT; n++) send_beat(n, (n == TOT - 1), (n == TOT - 1), 1'b0);
        check("fs_with_last_readi", {31'd0, readi}, 32'd0);
        repeat (3) cyc();
        check("fs_with_last_ignored", {31'd0, coef_valid}, 32'd0);
        swap(0);
        read_all();
        cyc();
        check("hold_rd_re", {16'd0, rd_re}, 32'd7);
        check("hold_rd_im", {16'd0, rd_im}, {16'd0, 16'hFFF9});

        // Short set: tlast on the 5th word
        exp_err_q.push_back(2);
        for (int n = 0; n < 5; n++) send_beat(50 + n, (n == 4), 1'b0, 1'b0);
        check("err_short_timing", {31'd0, err_short}, 32'd1);
        check("short_readi", {31'd0, readi}, 32'd1);
        cyc();
        check("err_short_one_cycle", {31'd0, err_short}, 32'd0);
        send_set(200, 1'b0);
        swap(200);
        read_all();

        // Long set: 8 words without tlast, then 3 dropped words
        exp_err_q.push_back(1);
        for (int n = 0; n < TOT; n++) send_beat(60 + n, 1'b0, 1'b0, 1'b0);
        check("err_long_timing", {31'd0, err_long}, 32'd1);
        for (int n = 0; n < 3; n++) send_beat(70 + n, (n == 2), 1'b0, 1'b0);
        check("drop_readi", {31'd0, readi}, 32'd1);
        check("drop_valid", {31'd0, coef_valid}, 32'd1);
        send_set(300, 1'b0);
        swap(300);
        read_all();

        // Continuous reads across a delayed swap
        send_set(400, 1'b0);
        for (int i = 0; i < 20; i++) begin
            push_read(i % TOT);
            cyc();
            check("pend_readi_hold", {31'd0, readi}, 32'd0);
        end
        push_read(3);
        fs = 1'b1;
        cyc();
        fs          = 1'b0;
        act_base    = 400;
        check("readi_after_swap", {31'd0, readi}, 32'd1);
        for (int k = 0; k < TOT; k++) begin
            push_read(k);
            cyc();
        end
        rd_en = 1'b0;
        cyc();

        // Random valid gaps must not change stored data
        send_set(600, 1'b1);
        swap(600);
        read_all();

        // Reset in the middle of the 4th beat
        for (int n = 0; n < 3; n++) send_beat(700 + n, 1'b0, 1'b0, 1'b0);
        vld   = 1'b1;
        re_in = 16'd703;
        im_in = 16'(-703);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_readi", {31'd0, readi}, 32'd0);
        check("mid_rst_valid", {31'd0, coef_valid}, 32'd0);
        check("mid_rst_rd_re", {16'd0, rd_re}, 32'd0);
        check("mid_rst_rd_im", {16'd0, rd_im}, 32'd0);
        check("mid_rst_errs", {30'd0, err_short, err_long}, 32'd0);
        vld = 1'b0;
        model_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        check("readi_after_mid_rst", {31'd0, readi}, 32'd1);
        send_set(800, 1'b0);
        swap(800);
        read_all();

        repeat (3) cyc();
        check("rd_queue_drained", exp_re_q.size(), 32'd0);
        check("err_queue_drained", exp_err_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fdn_coef_loader.md
# fdn_coef_loader

AXI-Stream slave that receives the complex beamforming coefficient stream (Re/Im lanes sharing one handshake) and stores it in a double-buffered coefficient memory for the FDN datapath. A complete, length-checked set is written into the shadow bank and becomes active only at the next frame boundary signalled by the core, so beams are never computed from a half-updated set. It sits between the coefficient AXI-Stream master and the FDN multiply array, which reads coefficients through a synchronous read port.

## Interface
Parameters:
- wight_coef_i, 16, width of each coefficient lane (Re and Im), two's complement
- N_chanals, 16, number of antenna channels
- N_DN, 4, number of beams; set size TOTAL = N_chanals*N_DN

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-low reset
- vld_coef_in  in  1  stream tvalid
- last_coef_in  in  1  stream tlast, marks final word of a set
- readi_coef_in  out  1  stream tready
- coefReIn  in  wight_coef_i  real coefficient
- coefImIn  in  wight_coef_i  imaginary coefficient
- frame_start  in  1  one-cycle pulse from core at a beam-frame boundary
- rd_en  in  1  read strobe
- rd_addr  in  $clog2(TOTAL)  read index k = dn*N_chanals + ch
- rd_coefRe  out  wight_coef_i  real coefficient from active bank
- rd_coefIm  out  wight_coef_i  imaginary coefficient from active bank
- coef_valid  out  1  an active set exists
- err_short  out  1  one-cycle pulse: tlast before TOTAL words
- err_long  out  1  one-cycle pulse: TOTAL words without tlast

## Operation
- Stream order: beam outer, channel inner; word n written to shadow address n.
- Beat accepted when vld_coef_in && readi_coef_in on a rising clk.
- States: LOAD, PEND, DROP. Reset state LOAD, cnt = 0.
- LOAD: readi 1. Each accepted beat writes shadow[cnt], cnt++.
  - Beat with last and cnt == TOTAL-1 -> PEND.
  - Beat with last and cnt < TOTAL-1 -> err_short pulse, cnt = 0, stay LOAD, shadow contents discarded; active bank untouched.
  - Beat without last at cnt == TOTAL-1 -> err_long pulse, -> DROP.
- DROP: readi 1, beats discarded; accepted beat with last -> LOAD, cnt = 0.
- PEND: readi 0. On frame_start: active_bank toggles, coef_valid <= 1, cnt = 0, -> LOAD.
- frame_start outside PEND is ignored. frame_start in the same cycle as the final beat is ignored; the swap waits for the next pulse.
- Read: rd_en registers active-bank data on rd_coefRe/Im. A read in the swap cycle returns the pre-swap bank; reads from the next cycle return the new bank. Without rd_en, outputs hold.
- No arithmetic on data; widths pass through unchanged.

## Timing
- Reset values: readi_coef_in 0, rd_coefRe/Im 0, coef_valid 0, err_short 0, err_long 0, active_bank 0.
- readi_coef_in is registered: rises the first clk after reset release; falls the cycle after the final beat is accepted; rises the cycle after the swap.
- Read latency 1 cycle; rd_en may be asserted every cycle.
- Errors pulse exactly one cycle, in the cycle after the offending beat.
- Reset asserted mid-load or in PEND aborts everything: the shadow set is lost and coef_valid returns to 0.
- Minimum reload period: TOTAL accepted cycles + wait for frame_start + 1.

## Structure
- Package fdn_coef_pkg: state enum (LOAD, PEND, DROP), localparam function for TOTAL and address width.
- Sub-module fdn_coef_bank: 2*TOTAL x (2*wight_coef_i) storage, one write port (bank, addr, data) and one registered read port (bank, addr). Maps to BRAM/LUTRAM.
- The top level holds the FSM, counter, bank pointer and error flags.

## Test plan
Bench uses N_chanals=4, N_DN=2, TOTAL=8.
- Reset, then stream 8 words Re=n, Im=-n with last on n=7, pulse frame_start -> coef_valid=1; reading k=0..7 returns Re=k, Im=-k with 1-cycle latency.
- tlast on the 5th word -> err_short pulse, readi stays 1; a following good 8-word set loads correctly.
- 8 words without last, then 3 more with last on the 3rd -> err_long once, DROP discards the extra words; next good set loads.
- Good set B loaded while set A is active, with continuous reads and frame_start delayed 20 cycles -> reads return A until the swap cycle inclusive, B afterwards; readi low throughout PEND.
- Random vld_coef_in gaps (about 50%) -> identical memory contents to the gap-free case.
- rst asserted in the middle of the 4th beat -> all outputs return to reset values; a new full set then loads normally.
